// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: FSM state type,
// default geometry and the hard-wired zero register address.
package regfile_pkg;

    // Sweep state: CLEAR zeroes the array one entry per cycle, RUN is normal use
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Default geometry: 32 registers of 32 bits
    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;

    // Address that reads as zero when the zero register is enabled
    localparam int ZERO_ADDR = 0;

    // An address can hold data / be a producer target unless it is the
    // hard-wired zero register.
    function automatic logic addr_writable(input int zero_reg, input int addr);
        return !((zero_reg != 0) && (addr == ZERO_ADDR));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pend bit per register, set by instruction
// issue and cleared by writeback, with issue taking priority on a same-address
// collision because the newer producer is still outstanding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_addr_i,
    input  logic          wb_valid_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic          busy1_o,
    output logic          busy2_o
);

    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Per-register next-state: the zero register never becomes pending, and a
    // set on the same cycle as a clear leaves the bit set.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            logic set_hit;
            logic clr_hit;

            assign set_hit = en_i && iss_valid_i && (iss_addr_i == AW'(gi))
                             && addr_writable(ZERO_REG, gi);
            assign clr_hit = en_i && wb_valid_i && (wb_addr_i == AW'(gi));
            assign pend_d[gi] = set_hit | (pend_q[gi] & ~clr_hit);
        end
    endgenerate

    // Pend vector register; reset forgets every outstanding producer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Each read port looks up its own register independently
    assign busy1_o = pend_q[ra1_i];
    assign busy2_o = pend_q[ra2_i];

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with a post-reset clear sweep and a pending-write
// scoreboard feeding per-port busy flags to the hazard unit.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle forwarding of the
// writeback data (and suppression of busy) onto a read port addressing wa.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    output logic          busy1,
    output logic          busy2,
    output logic          ready
);

    localparam int            NREG      = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          ready_q;

    logic [DW-1:0] mem_q [NREG];

    logic run;
    logic clr_en;
    logic wr_ok;
    logic wr_en;

    assign run    = (state_q == ST_RUN);
    assign clr_en = (state_q == ST_CLEAR);
    assign wr_ok  = addr_writable(ZERO_REG, int'(wa));
    // Writeback is only honoured once the sweep has finished
    assign wr_en  = run && we && wr_ok;

    // Sweep FSM: walk cnt across every address, then hand over to RUN with
    // ready raised on the same edge that clears the last register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;

    // Storage array: sweep writes zeros, RUN takes writeback data. No reset on
    // the array itself; the sweep is what guarantees a known state.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[wa] <= wd;
        end
    end

    logic sb_busy1;
    logic sb_busy2;

    regfile_scoreboard #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .en_i        (run),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .wb_valid_i  (we),
        .wb_addr_i   (wa),
        .ra1_i       (ra1),
        .ra2_i       (ra2),
        .busy1_o     (sb_busy1),
        .busy2_o     (sb_busy2)
    );

    logic [1:0][AW-1:0] ra_pk;
    logic [1:0]         sb_busy_pk;

    assign ra_pk      = {ra2, ra1};
    assign sb_busy_pk = {sb_busy2, sb_busy1};

    // Two identical, independent read ports
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DW-1:0] rd_val;
            logic          busy_val;

            // Read mux: silent during the sweep, zero register forced to 0,
            // optional forwarding of the in-flight writeback.
            always_comb begin
                rd_val   = '0;
                busy_val = 1'b0;
                if (run && addr_writable(ZERO_REG, int'(ra_pk[gi]))) begin
`ifdef REGFILE_BYPASS_EN
                    if (wr_en && (wa == ra_pk[gi])) begin
                        rd_val   = wd;
                        busy_val = 1'b0;
                    end else begin
                        rd_val   = mem_q[ra_pk[gi]];
                        busy_val = sb_busy_pk[gi];
                    end
`else
                    rd_val   = mem_q[ra_pk[gi]];
                    busy_val = sb_busy_pk[gi];
`endif
                end
            end
        end
    endgenerate

    assign rd1   = g_rd[0].rd_val;
    assign rd2   = g_rd[1].rd_val;
    assign busy1 = g_rd[0].busy_val;
    assign busy2 = g_rd[1].busy_val;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (DW=32, AW=5, ZERO_REG=1).
module tb_regfile_sb;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic        busy1;
    logic        busy2;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_sb #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy1     (busy1),
        .busy2     (busy2),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The file is "usable" once NREG rst-low edges have elapsed; at that point
    // every register is zero and nothing is pending.
    logic [31:0] m_mem  [NREG];
    bit          m_pend [NREG];
    int          m_low = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_low = 0;
        end else if (m_low < NREG) begin
            m_low = m_low + 1;
        end else begin
            if (we && wa != 0) m_mem[wa] = wd;
            if (we) m_pend[wa] = 1'b0;
            if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (rst || m_low < NREG || ra == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 0 && wa == ra) return wd;
`endif
        return m_mem[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        if (rst || m_low < NREG || ra == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == ra) return 1'b0;
`endif
        return m_pend[ra];
    endfunction

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("m_ready", 32'(ready), 32'(!rst && m_low >= NREG));
        chk("m_rd1",   rd1, exp_rd(ra1));
        chk("m_rd2",   rd2, exp_rd(ra2));
        chk("m_busy1", 32'(busy1), 32'(exp_busy(ra1)));
        chk("m_busy2", 32'(busy2), 32'(exp_busy(ra2)));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_and_check(input string tag);
        for (int k = 1; k <= NREG; k++) begin
            step();
            chk(tag, 32'(ready), 32'(k >= NREG));
        end
    endtask

    initial begin
        // Clear sweep from power-on reset
        step(); step();
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        rst = 1'b0;
        sweep_and_check("sweep_ready");
        $display("sweep done, ready=%0b", ready);

        for (int i = 0; i < NREG; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("clear_rd1", rd1, 32'h0);
            chk("clear_rd2", rd2, 32'h0);
            step();
        end

        // Reset mid-sweep: rst at cycle 10 for 2 cycles
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'h0);
        step(); step();
        rst = 1'b0;
        sweep_and_check("resweep_ready");
        $display("mid-sweep reset recovered, ready=%0b", ready);

        // Write/read on register 5
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr_same_rd1", rd1, 32'hDEADBEEF);
`else
        chk("wr_same_rd1", rd1, 32'h0);
`endif
        chk("wr_same_busy1", 32'(busy1), 32'h0);
        step();
        we = 1'b0;
        #1;
        chk("wr_next_rd1", rd1, 32'hDEADBEEF);
        $display("write reg5 rd1=%h", rd1);

        // Zero register: write and issue to address 0
        we = 1'b1; wa = 5'd0; wd = 32'h1234; iss_valid = 1'b1; iss_addr = 5'd0; ra1 = 5'd0;
        step();
        we = 1'b0; iss_valid = 1'b0;
        #1;
        chk("zero_rd1", rd1, 32'h0);
        chk("zero_busy1", 32'(busy1), 32'h0);
        $display("zero reg rd1=%h busy1=%0b", rd1, busy1);

        // Scoreboard on register 7
        iss_valid = 1'b1; iss_addr = 5'd7; ra2 = 5'd7;
        #1;
        chk("sb_issue_cyc", 32'(busy2), 32'h0);
        step();
        iss_valid = 1'b0;
        #1;
        chk("sb_after_issue", 32'(busy2), 32'h1);
        iss_valid = 1'b1; iss_addr = 5'd7;   // re-issue while pending
        step();
        iss_valid = 1'b0;
        #1;
        chk("sb_reissue", 32'(busy2), 32'h1);
        we = 1'b1; wa = 5'd7; wd = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("sb_wb_cyc", 32'(busy2), 32'h0);
`else
        chk("sb_wb_cyc", 32'(busy2), 32'h1);
`endif
        step();
        we = 1'b0;
        #1;
        chk("sb_after_wb", 32'(busy2), 32'h0);
        chk("sb_rd2", rd2, 32'h77);
        iss_valid = 1'b1; iss_addr = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h88;
        step();
        iss_valid = 1'b0; we = 1'b0;
        #1;
        chk("sb_collide_busy", 32'(busy2), 32'h1);
        chk("sb_collide_rd2", rd2, 32'h88);
        we = 1'b1; wa = 5'd7; wd = 32'h99;
        step();
        we = 1'b0;
        #1;
        chk("sb_final_busy", 32'(busy2), 32'h0);
        $display("scoreboard reg7 busy2=%0b rd2=%h", busy2, rd2);

        // Dual port same register
        we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5;
        step();
        we = 1'b0; ra1 = 5'd3; ra2 = 5'd3;
        #1;
        chk("dual_rd1", rd1, 32'hA5A5A5A5);
        chk("dual_rd2", rd2, 32'hA5A5A5A5);
        $display("dual port rd1=%h rd2=%h", rd1, rd2);

        // Fill every register with a distinct pattern, read back through both ports
        for (int i = 1; i < NREG; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h01010101;
            step();
        end
        we = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            ra1 = 5'(i); ra2 = 5'(NREG - i);
            #1;
            chk("fill_rd1", rd1, 32'(i) * 32'h01010101);
            chk("fill_rd2", rd2, 32'(NREG - i) * 32'h01010101);
            step();
        end

        // Reset in RUN: data and pend must not survive
        iss_valid = 1'b1; iss_addr = 5'd9; ra1 = 5'd9;
        step();
        iss_valid = 1'b0;
        #1;
        chk("run_busy_pre", 32'(busy1), 32'h1);
        rst = 1'b1;
        #1;
        chk("run_rst_ready", 32'(ready), 32'h0);
        step();
        rst = 1'b0;
        sweep_and_check("run_resweep");
        #1;
        chk("run_rst_rd1", rd1, 32'h0);
        chk("run_rst_busy1", 32'(busy1), 32'h0);
        $display("reset in RUN cleared reg9 rd1=%h", rd1);

        // Mixed traffic checked by the model
        for (int c = 0; c < 300; c++) begin
            we        = 1'($urandom_range(1, 0));
            wa        = 5'($urandom_range(31, 0));
            wd        = $urandom;
            iss_valid = 1'($urandom_range(1, 0));
            iss_addr  = 5'($urandom_range(31, 0));
            ra1       = (c % 4 == 0) ? wa : 5'($urandom_range(31, 0));
            ra2       = (c % 5 == 0) ? iss_addr : 5'($urandom_range(31, 0));
            step();
        end
        we = 1'b0; iss_valid = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the pipelined CPU, with a pending-write scoreboard and a counter-driven clear sweep after reset. It replaces the fixed 32x32 register file in the decode stage. Every register is zeroed by hardware after reset instead of relying on simulation-only initialisation. Read-after-write hazards are reported to the hazard unit through per-read-port busy flags.

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 5, address width; number of registers NREG = 2**AW
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and issues

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  DW  read data, port 1, combinational
- rd2  out  DW  read data, port 2, combinational
- we  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  DW  writeback data
- iss_valid  in  1  an instruction that will write iss_addr issues this cycle
- iss_addr  in  AW  destination register of the issuing instruction
- busy1  out  1  register ra1 has a pending write not yet visible on rd1
- busy2  out  1  register ra2 has a pending write not yet visible on rd2
- ready  out  1  clear sweep complete; file usable

## Operation
- State machine with two states:
  - CLEAR: entered asynchronously on rst, with sweep counter cnt=0. Each cycle after rst deasserts, mem[cnt] is written to 0 and cnt increments. From cnt=NREG-1 the machine moves to RUN.
  - RUN: normal operation.
- Reset values: ready=0, all pend bits 0, cnt=0. During CLEAR, rd1=rd2=0 and busy1=busy2=0.
- In CLEAR, we and iss_valid are ignored.
- Write in RUN: if we=1 and the address is writable, mem[wa] takes wd at the rising edge. A register is not writable only when ZERO_REG=1 and wa=0.
- Scoreboard: one pend bit per register.
  - iss_valid sets pend[iss_addr].
  - we clears pend[wa].
  - If issue and writeback hit the same address in the same cycle, set wins, because a newer producer is outstanding.
  - Issue to an already-pending address leaves pend set.
- With ZERO_REG=1, address 0 is never pending and always reads 0.
- busyN = pend[raN], except as modified by the bypass in Configuration.
- Both read ports may address the same register; they are fully independent.

## Timing
- Read latency is 0 cycles: combinational from raN.
- Write latency: a value is visible on rd the cycle after the write edge. With bypass compiled in, it is visible in the same cycle.
- Scoreboard updates are visible on busyN the cycle after the edge.
- ready rises exactly NREG cycles after rst deasserts (first edge with rst low counts as cycle 1).
- rst asserted mid-sweep or in RUN aborts immediately. Sweep and scoreboard restart; no partial state survives.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - In RUN, if we=1, wa is writable and wa==raN, then rdN=wd and busyN=0 in that same cycle.
- REGFILE_BYPASS_EN undefined: no forwarding.
  - rdN returns the old mem value during the write cycle.
  - busyN stays equal to pend[raN] until the edge.

## Structure
- Shared package regfile_pkg holds:
  - state enumeration (CLEAR, RUN)
  - default DW/AW constants
  - the zero-address constant
- Sub-module regfile_scoreboard holds the pend vector, the set/clear priority logic and the two busy lookups.
- The top module holds the storage array, the sweep counter/FSM and the read muxes.

## Test plan
- Clear sweep, DW=32, AW=5: pulse rst, then hold rst low. Response:
  - ready=0 for cycles 1..31, ready=1 from cycle 32.
  - Reading all 32 registers then returns 0.
- Reset mid-sweep: assert rst at cycle 10 for 2 cycles. Response:
  - ready falls immediately.
  - ready rises exactly 32 cycles after the second deassert.
- Write/read: we=1, wa=5, wd=0xDEADBEEF, ra1=5 in the same cycle. Response:
  - With REGFILE_BYPASS_EN, rd1=0xDEADBEEF and busy1=0 in that cycle.
  - Without it, rd1 is the old value that cycle and 0xDEADBEEF next cycle.
- Zero register: we=1, wa=0, wd=0x1234, plus iss_valid=1, iss_addr=0. Response: rd1=0 with ra1=0, and busy1 stays 0.
- Scoreboard: issue to register 7, then hold ra2=7. Response:
  - busy2=1 from the next cycle until the cycle after writeback to register 7.
  - Simultaneous issue and writeback to 7 leaves busy2=1.
- Dual port: ra1=ra2=3 after writing 0xA5A5A5A5 to register 3. Response: rd1=rd2=0xA5A5A5A5.
